alu_result_fifo: RTL and testbench

Downstream stage of the 4-bit add/subtract ALU. Captures each ALU result (Q, carry/borrow c, op select s) into a small first-word-fall-through FIFO with a valid/ready handshake, so a slower consumer can drain results. Also derives a zero flag per entry and keeps saturating counts of add-carry and sub-borrow events for status/debug.

---
 rtl/alu_result_fifo.sv | 106 ++++++++++
 tb/tb_alu_result_fifo.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_fifo.sv
// First-word-fall-through FIFO buffering ALU results (q, carry/borrow, op)
// with a per-entry zero flag and saturating carry/borrow event counters.
module alu_result_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_q,
  input  logic                     in_c,
  input  logic                     in_s,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_q,
  output logic                     out_c,
  output logic                     out_s,
  output logic                     out_zero,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [CNT_W-1:0]         carry_cnt,
  output logic [CNT_W-1:0]         borrow_cnt
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_FW = PTR_W + 1;
  localparam int unsigned ENT_W  = WIDTH + 2;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [ENT_W-1:0] head;
  logic             push;
  logic             pop;
  logic             push_en;
  logic             pop_en;

  // Status derived only from the registered count; out_ready never reaches in_ready.
  assign full      = (count == CNT_FW'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = ~full;
  assign out_valid = ~empty;

  assign push    = in_valid & in_ready;
  assign pop     = out_valid & out_ready;
  assign push_en = push & ~flush;
  assign pop_en  = pop & ~flush;

  // Head entry falls through combinationally; zeroed while empty.
  assign head     = mem[rd_ptr];
  assign out_q    = empty ? '0   : head[WIDTH-1:0];
  assign out_c    = empty ? 1'b0 : head[WIDTH];
  assign out_s    = empty ? 1'b0 : head[WIDTH+1];
  assign out_zero = out_valid & (out_q == '0);

  // Storage carries no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem[wr_ptr] <= {in_s, in_c, in_q};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_en) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_en, pop_en})
        2'b10:   count <= count + CNT_FW'(1);
        2'b01:   count <= count - CNT_FW'(1);
        default: count <= count;
      endcase
    end
  end

  // Event counters survive flush and stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_cnt  <= '0;
      borrow_cnt <= '0;
    end else if (push_en && in_c) begin
      if (in_s && (carry_cnt != '1)) begin
        carry_cnt <= carry_cnt + CNT_W'(1);
      end
      if (!in_s && (borrow_cnt != '1)) begin
        borrow_cnt <= borrow_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Scoreboard bench for alu_result_fifo: queue-based reference model updated at
// each rising edge, independent monitor comparing all outputs on falling edges.
module tb_alu_result_fifo;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned SAT   = 255;

  typedef struct packed {
    logic [WIDTH-1:0] q;
    logic             c;
    logic             s;
  } ent_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_q;
  logic             in_c;
  logic             in_s;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_q;
  logic             out_c;
  logic             out_s;
  logic             out_zero;
  logic [2:0]       count;
  logic             full;
  logic             empty;
  logic [CNT_W-1:0] carry_cnt;
  logic [CNT_W-1:0] borrow_cnt;

  int errors = 0;
  int checks = 0;

  ent_t sb[$];
  int   carry_m  = 0;
  int   borrow_m = 0;

  alu_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_q(in_q), .in_c(in_c), .in_s(in_s),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_q(out_q), .out_c(out_c), .out_s(out_s), .out_zero(out_zero),
    .count(count), .full(full), .empty(empty),
    .carry_cnt(carry_cnt), .borrow_cnt(borrow_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: accept when room, drain when non-empty, flush wins.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb.delete();
      carry_m  = 0;
      borrow_m = 0;
    end else begin
      bit   acc;
      bit   pp;
      ent_t e;
      acc = (in_valid === 1'b1) && (sb.size() < DEPTH);
      pp  = (out_ready === 1'b1) && (sb.size() > 0);
      if (flush === 1'b1) begin
        sb.delete();
      end else begin
        if (pp) void'(sb.pop_front());
        if (acc) begin
          e.q = in_q; e.c = in_c; e.s = in_s;
          sb.push_back(e);
          if (in_c && in_s && carry_m < SAT) carry_m++;
          if (in_c && !in_s && borrow_m < SAT) borrow_m++;
        end
      end
    end
  end

  // Monitor: every falling edge, compare the presented head and status.
  always @(negedge clk) begin
    bit   v;
    ent_t h;
    v = (sb.size() > 0);
    h = v ? sb[0] : '0;
    chk("out_valid", 32'(out_valid), 32'(v));
    chk("out_q",     32'(out_q),     32'(h.q));
    chk("out_c",     32'(out_c),     32'(h.c));
    chk("out_s",     32'(out_s),     32'(h.s));
    chk("out_zero",  32'(out_zero),  32'(v && (h.q == 0)));
    chk("count",     32'(count),     32'(sb.size()));
    chk("full",      32'(full),      32'(sb.size() == DEPTH));
    chk("empty",     32'(empty),     32'(sb.size() == 0));
    chk("in_ready",  32'(in_ready),  32'(sb.size() < DEPTH));
    chk("carry_cnt", 32'(carry_cnt), 32'(carry_m));
    chk("borrow_cnt",32'(borrow_cnt),32'(borrow_m));
  end

  // Apply inputs at a falling edge and advance to the next falling edge.
  task automatic drive(input logic v, input logic [WIDTH-1:0] q, input logic c,
                       input logic s, input logic r, input logic f);
    in_valid = v; in_q = q; in_c = c; in_s = s; out_ready = r; flush = f;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_q = '0;
    in_c = 1'b0; in_s = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_q", 32'(out_q), 32'd0);

    // Single push: visible one cycle later.
    drive(1, 4'd5, 0, 1, 0, 0);
    chk("lat_valid", 32'(out_valid), 32'd1);
    chk("lat_q", 32'(out_q), 32'd5);
    chk("lat_zero", 32'(out_zero), 32'd0);
    chk("lat_count", 32'(count), 32'd1);
    chk("lat_carry", 32'(carry_cnt), 32'd0);
    drive(0, 0, 0, 0, 1, 0);

    // Fill to full, fifth offer refused, then drain in order.
    drive(1, 4'd1, 0, 0, 0, 0);
    drive(1, 4'd2, 0, 0, 0, 0);
    drive(1, 4'd3, 0, 0, 0, 0);
    drive(1, 4'd0, 0, 0, 0, 0);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    drive(1, 4'd9, 0, 1, 0, 0);
    chk("fill_hold_count", 32'(count), 32'd4);
    chk("fill_head", 32'(out_q), 32'd1);
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 0);
    chk("drain_last_q", 32'(out_q), 32'd0);
    chk("drain_last_zero", 32'(out_zero), 32'd1);
    drive(0, 0, 0, 0, 1, 0);
    chk("drain_empty", 32'(empty), 32'd1);
    chk("drain_zero_off", 32'(out_zero), 32'd0);

    // Steady push+pop at count 2 across pointer wrap.
    drive(1, 4'd10, 0, 0, 0, 0);
    drive(1, 4'd11, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) drive(1, WIDTH'(i), 0, 1, 1, 0);
    chk("stream_count", 32'(count), 32'd2);
    chk("stream_head", 32'(out_q), 32'd8);

    // Flush with concurrent push and pop at count 3.
    drive(1, 4'd4, 0, 1, 0, 0);
    chk("pre_flush_count", 32'(count), 32'd3);
    drive(1, 4'd7, 1, 1, 1, 1);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_carry", 32'(carry_cnt), 32'd0);

    // Carry counter saturation, then one borrow.
    for (int i = 0; i < 300; i++) drive(1, WIDTH'($urandom), 1, 1, 1, 0);
    chk("carry_sat", 32'(carry_cnt), 32'd255);
    chk("borrow_zero", 32'(borrow_cnt), 32'd0);
    drive(1, 4'd3, 1, 0, 1, 0);
    chk("borrow_one", 32'(borrow_cnt), 32'd1);
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 0);

    // Random traffic with occasional flush.
    for (int i = 0; i < 400; i++)
      drive(1'($urandom_range(0, 1)), WIDTH'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 31) == 0));

    // Asynchronous reset between edges with two entries held.
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 0);
    drive(1, 4'd6, 1, 1, 0, 0);
    drive(1, 4'd2, 1, 0, 0, 0);
    in_valid = 1'b0;
    chk("pre_rst_count", 32'(count), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_carry", 32'(carry_cnt), 32'd0);
    chk("arst_borrow", 32'(borrow_cnt), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
